uart_frame_transmit: RTL and testbench
======================================

Name: uart_frame_transmit

Overview:
- Serialises one WIDTH-bit word as a sequence of 8N1 UART bytes.
- It is the transmit-side counterpart of the wide-word receiver, so the board can emit full {modulus, exponent, value} request frames.
- Used for loopback self-test of the expmod path and for driving a second board.
- Sits between a word producer (ready/data handshake) and the physical TX pin.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 115_200, line rate. CPB = CLK_FREQ / BAUD_RATE (integer truncation) cycles per bit; CPB >= 2 required.
- WIDTH, 80, payload word width in bits. NUM_BYTES = ceil(WIDTH/8).
- GAP_BITS, 0, idle (mark) bit-times inserted after each byte's stop bit, including after the last byte.

Ports:
- clk_in, input, 1, system clock.
- rst_in, input, 1, asynchronous active-low reset.
- data_in, input, WIDTH, word to send; sampled only at acceptance.
- ready_in, input, 1, request strobe from producer.
- busy_out, output, 1, high while a frame is in flight.
- done_out, output, 1, one-cycle pulse when the frame completes.
- tx_wire_out, output, 1, serial line; idle high.

Behaviour:
- Reset (rst_in low, asynchronous): tx_wire_out=1, busy_out=0, done_out=0, state IDLE, all counters 0.
- Reset asserted mid-frame aborts immediately: line returns high and the partial frame is discarded.
- Acceptance: on a clock edge with ready_in=1 and busy_out=0:
  - data_in is latched into a WIDTH-bit shadow register, zero-padded to NUM_BYTES*8.
  - busy_out<=1 and tx_wire_out<=0 (start bit) on the same edge.
- ready_in while busy_out=1 is ignored. There is no queueing and data_in changes have no effect.
- Byte order: least-significant byte first. Bit order within a byte: LSB first. This matches the receiver's packing, so bits [7:0] go on the wire first.
- Per byte: start bit (0), 8 data bits, 1 stop bit (1), then GAP_BITS mark bits. Each bit holds for exactly CPB cycles.
- State machine:
  - IDLE -> START on acceptance.
  - START -> DATA after CPB cycles.
  - DATA -> DATA for bit_idx 0..7, each CPB cycles; DATA -> STOP after bit 7.
  - STOP -> GAP if GAP_BITS>0, else -> next byte/finish.
  - GAP -> next byte/finish after GAP_BITS*CPB cycles.
  - Next byte: byte_idx<NUM_BYTES-1 -> START with byte_idx+1, driving the start bit immediately with no extra idle cycle.
  - Finish: byte_idx==NUM_BYTES-1 -> IDLE.
- Finish edge: busy_out<=0 and done_out<=1 on the same edge; done_out returns to 0 the next edge.
- A new ready_in is accepted in the first cycle busy_out is low, i.e. concurrent with done_out=1.
- Frame length: busy_out is high for exactly NUM_BYTES*(10+GAP_BITS)*CPB cycles.
- Counters:
  - baud_cnt: $clog2(CPB) bits, wraps 0..CPB-1.
  - bit_idx: 3 bits.
  - byte_idx: $clog2(NUM_BYTES)+1 bits.
  - gap counter: counts bit-times.
  - No counter may overflow at maximum parameter values.
- tx_wire_out is registered (glitch-free). All outputs are registered.

Decomposition:
- Shared package uart_pkg holds:
  - typedef enum tx_state_t {IDLE, START, DATA, STOP, GAP};
  - localparams BITS_PER_BYTE=8 and FRAME_BITS=10;
  - function cycles_per_bit(clk, baud).
- Sub-module baud_counter (parameter CPB; ports clk_in, rst_in, clear_in, tick_out) produces a one-cycle tick every CPB cycles. It restarts on clear_in, which is asserted at acceptance.
- The byte/bit sequencing FSM stays in uart_frame_transmit.

Test Plan:
- Common setup: CLK_FREQ=100_000_000, BAUD_RATE=12_500_000 (CPB=8), WIDTH=16, GAP_BITS=0 unless stated.
- Basic frame:
  - Stimulus: data_in=16'hA55A, ready_in pulse.
  - Line: 0,0,1,0,1,1,0,1,0,1 then 0,1,0,1,0,0,1,0,1,1; each bit exactly 8 cycles.
  - busy_out high 160 cycles; done_out single pulse on the falling edge of busy_out.
- Padding, WIDTH=12:
  - Stimulus: data_in=12'hFFF.
  - Second byte data bits = 1,1,1,1,0,0,0,0; busy_out 160 cycles.
- Ignored request:
  - Stimulus: ready_in=1 with data_in=16'h0000 at cycle 50 of a 16'h1234 frame.
  - Wire carries 0x34 then 0x12 only; exactly one done_out.
- Back-to-back, GAP_BITS=1:
  - Stimulus: hold ready_in=1 continuously with 16'h0102 then 16'h0304.
  - Second start bit begins on the cycle after done_out.
  - Each frame 176 cycles; 8-cycle mark gap after every stop bit.
- Async reset:
  - Stimulus: rst_in low for 3 cycles mid-DATA of byte 0, asserted between clock edges.
  - tx_wire_out=1 and busy_out=0 before the next edge; no done_out.
  - A subsequent 16'hBEEF frame is transmitted correctly.
- Loopback: connect tx_wire_out to the wide receiver (WIDTH=80, CPB=868) and send 80'h00000435_00000048_0007; the receiver's valid_out data must match exactly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and constants used by the frame transmitter and its baud counter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    GAP
  } tx_state_t;

  localparam int BITS_PER_BYTE = 8;
  localparam int FRAME_BITS    = 10;

  function automatic int cycles_per_bit(input int clk, input int baud);
    return clk / baud;
  endfunction

endpackage

// File: rtl/uart_frame_transmit_baud_counter.sv
// Bit-time generator: one-cycle tick every CPB clocks, restarted by clear_in.
module baud_counter #(
  parameter int CPB = 868
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear_in,
  output logic tick_out
);

  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_end;

  always_comb begin
    at_end = (cnt_q == CNT_W'(CPB - 1));
    cnt_d  = cnt_q + 1'b1;
    if (clear_in || at_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_out = at_end;

endmodule

// File: rtl/uart_frame_transmit.sv
// Serialises one WIDTH-bit word as consecutive 8N1 bytes, LSB byte first, LSB bit first.
module uart_frame_transmit
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int WIDTH     = 80,
  parameter int GAP_BITS  = 0
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ready_in,
  output logic             busy_out,
  output logic             done_out,
  output logic             tx_wire_out,
  output tx_state_t        state_out
);

  localparam int CPB       = cycles_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int NUM_BYTES = (WIDTH + BITS_PER_BYTE - 1) / BITS_PER_BYTE;
  localparam int SH_W      = NUM_BYTES * BITS_PER_BYTE;
  localparam int BYTE_W    = $clog2(NUM_BYTES) + 1;
  localparam int GAP_W     = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam int GAP_LAST  = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;

  // Handshake: a word is taken on any edge where ready_in=1 and busy_out=0;
  // ready_in while busy_out=1 is dropped, there is no holding register.
  tx_state_t         state_q, state_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [BYTE_W-1:0] byte_idx_q, byte_idx_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              clear;
  logic              tick;
  logic              slot_end;

  baud_counter #(
    .CPB(CPB)
  ) u_baud (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .clear_in(clear),
    .tick_out(tick)
  );

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    gap_cnt_d  = gap_cnt_q;
    sh_d       = sh_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    clear      = 1'b0;
    slot_end   = 1'b0;

    case (state_q)
      IDLE: begin
        if (ready_in) begin
          sh_d       = SH_W'(data_in);
          state_d    = START;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          byte_idx_d = '0;
          bit_idx_d  = '0;
          clear      = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          tx_d    = sh_q[0];
        end
      end
      DATA: begin
        // Shifting on every data bit leaves the next byte at the LSB after bit 7.
        if (tick) begin
          sh_d      = sh_q >> 1;
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d = sh_q[1];
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (GAP_BITS > 0) begin
            state_d   = GAP;
            gap_cnt_d = '0;
          end else begin
            slot_end = 1'b1;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
            slot_end = 1'b1;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (slot_end) begin
      if (byte_idx_q == BYTE_W'(NUM_BYTES - 1)) begin
        state_d    = IDLE;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        tx_d       = 1'b1;
        byte_idx_d = '0;
      end else begin
        state_d    = START;
        byte_idx_d = byte_idx_q + 1'b1;
        tx_d       = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      gap_cnt_q  <= '0;
      sh_q       <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      gap_cnt_q  <= gap_cnt_d;
      sh_q       <= sh_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy_out    = busy_q;
  assign done_out    = done_q;
  assign tx_wire_out = tx_q;
  assign state_out   = state_q;

endmodule

// File: tb/tb_uart_frame_transmit.sv
// Bench for uart_frame_transmit: four configurations checked every cycle against a line model.
module tb_uart_frame_transmit;
  import uart_pkg::*;

  localparam int CPB = 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  ready = '0;
  logic [79:0] data [4];
  wire  [3:0]  busy;
  wire  [3:0]  done;
  wire  [3:0]  tx;
  tx_state_t   st0, st1, st2, st3;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  int cfg_w [4] = '{16, 12, 16, 80};
  int cfg_g [4] = '{0, 0, 1, 0};

  uart_frame_transmit #(.CLK_FREQ(100_000_000), .BAUD_RATE(12_500_000), .WIDTH(16), .GAP_BITS(0)) dut0 (
    .clk_in(clk), .rst_in(rst_n), .data_in(data[0][15:0]), .ready_in(ready[0]),
    .busy_out(busy[0]), .done_out(done[0]), .tx_wire_out(tx[0]), .state_out(st0));
  uart_frame_transmit #(.CLK_FREQ(100_000_000), .BAUD_RATE(12_500_000), .WIDTH(12), .GAP_BITS(0)) dut1 (
    .clk_in(clk), .rst_in(rst_n), .data_in(data[1][11:0]), .ready_in(ready[1]),
    .busy_out(busy[1]), .done_out(done[1]), .tx_wire_out(tx[1]), .state_out(st1));
  uart_frame_transmit #(.CLK_FREQ(100_000_000), .BAUD_RATE(12_500_000), .WIDTH(16), .GAP_BITS(1)) dut2 (
    .clk_in(clk), .rst_in(rst_n), .data_in(data[2][15:0]), .ready_in(ready[2]),
    .busy_out(busy[2]), .done_out(done[2]), .tx_wire_out(tx[2]), .state_out(st2));
  uart_frame_transmit #(.CLK_FREQ(100_000_000), .BAUD_RATE(12_500_000), .WIDTH(80), .GAP_BITS(0)) dut3 (
    .clk_in(clk), .rst_in(rst_n), .data_in(data[3]), .ready_in(ready[3]),
    .busy_out(busy[3]), .done_out(done[3]), .tx_wire_out(tx[3]), .state_out(st3));

  // ---------------- line model ----------------
  bit          m_act  [4];
  int          m_k    [4];
  bit          m_done [4];
  logic [79:0] m_word [4];

  function automatic int frame_len(int i);
    return ((cfg_w[i] + 7) / 8) * (10 + cfg_g[i]) * CPB;
  endfunction

  function automatic logic [79:0] width_mask(int w);
    logic [79:0] m;
    m = '1;
    return m >> (80 - w);
  endfunction

  // Line level k cycles after acceptance: start, 8 data bits LSB first, stop, gap marks.
  function automatic logic line_bit(int i, int k);
    int bt, slot, pos;
    bt   = k / CPB;
    slot = 10 + cfg_g[i];
    pos  = bt % slot;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return m_word[i][(bt / slot) * 8 + pos - 1];
    return 1'b1;
  endfunction

  function automatic logic exp_tx(int i);
    return m_act[i] ? line_bit(i, m_k[i]) : 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_act[i] = 1'b0; m_k[i] = 0; m_done[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        m_done[i] = 1'b0;
        if (m_act[i]) begin
          if (m_k[i] == frame_len(i) - 1) begin
            m_act[i] = 1'b0; m_done[i] = 1'b1;
          end else begin
            m_k[i]++;
          end
        end else if (ready[i]) begin
          m_act[i]  = 1'b1;
          m_k[i]    = 0;
          m_word[i] = data[i] & width_mask(cfg_w[i]);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      total++;
      if (tx[i] !== exp_tx(i) || busy[i] !== m_act[i] || done[i] !== m_done[i]) begin
        bad++;
        $display("FAIL cycle_cmp inst=%0d t=%0t got tx=%b busy=%b done=%b want tx=%b busy=%b done=%b",
                 i, $time, tx[i], busy[i], done[i], exp_tx(i), m_act[i], m_done[i]);
      end
    end
  end

  // ---------------- line recorder ----------------
  logic samp [4][0:255];
  int   samp_n [4], blen [4], cur_run [4], idle_run [4], run_n [4];
  int   done_cnt [4], done_bad [4], last_idle [4];
  int   runs [4][0:7];
  logic [3:0] prev_busy = '0;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (busy[i]) begin
        if (!prev_busy[i] && run_n[i] > 0) last_idle[i] = idle_run[i];
        if (blen[i] % CPB == 3 && samp_n[i] < 256) begin
          samp[i][samp_n[i]] = tx[i];
          samp_n[i]++;
        end
        blen[i]++;
        cur_run[i]++;
      end else begin
        if (prev_busy[i]) begin
          if (run_n[i] < 8) runs[i][run_n[i]] = cur_run[i];
          run_n[i]++;
          cur_run[i]  = 0;
          idle_run[i] = 0;
        end
        idle_run[i]++;
      end
      if (done[i]) begin
        done_cnt[i]++;
        if (busy[i] || !prev_busy[i]) done_bad[i]++;
      end
      prev_busy[i] = busy[i];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 4; i++) begin
      samp_n[i] = 0; blen[i] = 0; cur_run[i] = 0; idle_run[i] = 0; run_n[i] = 0;
      done_cnt[i] = 0; done_bad[i] = 0; last_idle[i] = -1;
      for (int r = 0; r < 8; r++) runs[i][r] = 0;
    end
    prev_busy = busy;
  endtask

  task automatic send(input int i, input logic [79:0] w);
    data[i]  = w;
    ready[i] = 1'b1;
    step(1);
    ready[i] = 1'b0;
  endtask

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic wait_done(input int i, input int target, input int budget, input string name);
    int c;
    c = 0;
    while (done_cnt[i] < target && c < budget) begin
      step(1);
      c++;
    end
    total++;
    if (done_cnt[i] < target) begin
      bad++;
      $display("FAIL %s_timeout got done_count=%0d want=%0d", name, done_cnt[i], target);
    end
  endtask

  function automatic logic [7:0] get_byte(int i, int b);
    logic [7:0] v;
    int base;
    base = b * (10 + cfg_g[i]);
    for (int j = 0; j < 8; j++) v[j] = samp[i][base + 1 + j];
    return v;
  endfunction

  function automatic logic [79:0] samp_vec(int i, int n);
    logic [79:0] v;
    v = '0;
    for (int j = 0; j < n; j++) v[j] = samp[i][j];
    return v;
  endfunction

  task automatic check_bytes(input int i, input string name);
    for (int b = 0; exp_q.size() > 0; b++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      check($sformatf("%s_byte%0d", name, b), 80'(get_byte(i, b)), 80'(e));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [79:0] word;
    for (int i = 0; i < 4; i++) data[i] = '0;
    rst_n = 1'b0;
    step(3);
    check("reset_tx", 80'(tx), 80'hF);
    check("reset_busy", 80'(busy), 80'h0);
    check("reset_done", 80'(done), 80'h0);
    check("reset_state", {68'h0, st0, st1, st2, st3}, {68'h0, IDLE, IDLE, IDLE, IDLE});
    rst_n = 1'b1;
    step(2);

    // Basic 16'hA55A frame
    clear_stats();
    send(0, 80'hA55A);
    wait_done(0, 1, 400, "basic");
    step(4);
    check("basic_line", samp_vec(0, 20), 80'(20'b1101001010_1010110100));
    check("basic_nsamp", 80'(samp_n[0]), 80'd20);
    check("basic_busy_len", 80'(runs[0][0]), 80'd160);
    check("basic_done_cnt", 80'(done_cnt[0]), 80'd1);
    check("basic_done_edge", 80'(done_bad[0]), 80'd0);
    exp_q.push_back(8'h5A); exp_q.push_back(8'hA5);
    check_bytes(0, "basic");

    // Zero padding of a 12-bit word
    clear_stats();
    send(1, 80'hFFF);
    wait_done(1, 1, 400, "pad");
    step(4);
    check("pad_byte1_bits", 80'(get_byte(1, 1)), 80'h0F);
    check("pad_busy_len", 80'(runs[1][0]), 80'd160);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h0F);
    check_bytes(1, "pad");

    // Request during a frame is ignored
    clear_stats();
    send(0, 80'h1234);
    step(48);
    data[0]  = '0;
    ready[0] = 1'b1;
    step(1);
    ready[0] = 1'b0;
    wait_done(0, 1, 400, "ignore");
    step(20);
    check("ignore_done_cnt", 80'(done_cnt[0]), 80'd1);
    check("ignore_frames", 80'(run_n[0]), 80'd1);
    check("ignore_busy_len", 80'(runs[0][0]), 80'd160);
    exp_q.push_back(8'h34); exp_q.push_back(8'h12);
    check_bytes(0, "ignore");

    // Back-to-back with one gap bit, ready held high
    clear_stats();
    data[2]  = 80'h0102;
    ready[2] = 1'b1;
    step(1);
    data[2] = 80'h0304;
    wait_done(2, 1, 400, "b2b_first");
    step(1);
    ready[2] = 1'b0;
    wait_done(2, 2, 400, "b2b_second");
    step(4);
    check("b2b_len0", 80'(runs[2][0]), 80'd176);
    check("b2b_len1", 80'(runs[2][1]), 80'd176);
    check("b2b_idle_between", 80'(last_idle[2]), 80'd1);
    check("b2b_gap_marks", 80'({samp[2][10], samp[2][21], samp[2][32], samp[2][43]}), 80'hF);
    check("b2b_nsamp", 80'(samp_n[2]), 80'd44);
    exp_q.push_back(8'h02); exp_q.push_back(8'h01);
    exp_q.push_back(8'h04); exp_q.push_back(8'h03);
    check_bytes(2, "b2b");

    // Asynchronous reset in the middle of byte 0 data bits
    clear_stats();
    send(0, 80'h5555);
    step(29);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_tx", 80'(tx[0]), 80'h1);
    check("arst_busy", 80'(busy[0]), 80'h0);
    check("arst_state", 80'(st0), 80'(IDLE));
    step(3);
    #2;
    rst_n = 1'b1;
    step(6);
    check("arst_no_done", 80'(done_cnt[0]), 80'd0);
    clear_stats();
    send(0, 80'hBEEF);
    wait_done(0, 1, 400, "after_rst");
    step(4);
    check("after_rst_busy_len", 80'(runs[0][0]), 80'd160);
    exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
    check_bytes(0, "after_rst");

    // Full-width 80-bit request frame, decoded from the line
    clear_stats();
    send(3, 80'h00000435_00000048_0007);
    wait_done(3, 1, 1200, "wide");
    step(4);
    word = '0;
    for (int b = 0; b < 10; b++) word[b*8 +: 8] = get_byte(3, b);
    check("wide_word", word, 80'h00000435_00000048_0007);
    check("wide_busy_len", 80'(runs[3][0]), 80'd800);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
